// File: rtl/udma_pkg.sv
// Shared constants for the uDMA stream datapath.
package udma_pkg;
   localparam int STREAM_ID_WIDTH = 8;
endpackage

// File: rtl/udma_stream_framer_if.sv
// Stream bundle between a peripheral sample source, the framer and the
// downstream filter.
//   in_*  : peripheral sample handshake (data/valid in, ready out of framer)
//   str_* : framed stream toward the filter (payload, datasize, id, sot, eot,
//           valid out of framer, ready back in)
// Modport slave is the framer's view; modport master is the environment
// (source plus filter) that surrounds it.
interface udma_stream_framer_if #(
   parameter int DATA_WIDTH   = 32,
   parameter int FILTID_WIDTH = 8
);
   logic [DATA_WIDTH-1:0]   in_data_i;
   logic                    in_valid_i;
   logic                    in_ready_o;
   logic [DATA_WIDTH-1:0]   str_data_o;
   logic [1:0]              str_datasize_o;
   logic [FILTID_WIDTH-1:0] str_stream_id_o;
   logic                    str_valid_o;
   logic                    str_sot_o;
   logic                    str_eot_o;
   logic                    str_ready_i;

   modport slave (
      input  in_data_i, in_valid_i, str_ready_i,
      output in_ready_o, str_data_o, str_datasize_o, str_stream_id_o,
             str_valid_o, str_sot_o, str_eot_o
   );

   modport master (
      output in_data_i, in_valid_i, str_ready_i,
      input  in_ready_o, str_data_o, str_datasize_o, str_stream_id_o,
             str_valid_o, str_sot_o, str_eot_o
   );
endinterface

// File: rtl/udma_stream_framer.sv
// Groups peripheral samples into frames of a configured length, stamps each
// beat with stream id / datasize / sot / eot and buffers them in a small
// registered FIFO toward the filter.
// Ports:
//   sys_clk_i, rst_i     clock, synchronous active-high reset
//   cfg_en_i             framing enable (takes effect at frame boundaries)
//   cfg_frame_len_i      beats per frame, 0 behaves as 1
//   cfg_stream_id_i      id stamped on the frame
//   cfg_datasize_i       datasize stamped on the frame
//   strm                 sample input and framed stream output (slave view)
//   frame_evt_o          one-cycle pulse after each delivered eot beat
//   frame_cnt_o          count of delivered frames, wraps
//   busy_o               frame in progress or buffered beats pending
//
// state | meaning
// IDLE  | framing disabled, buffer empty
// RUN   | accepting samples; stays here until the current frame completes
// DRAIN | disabled at a frame boundary, emptying the buffer
module udma_stream_framer #(
   parameter int DATA_WIDTH   = 32,
   parameter int FILTID_WIDTH = udma_pkg::STREAM_ID_WIDTH,
   parameter int LEN_WIDTH    = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                    sys_clk_i,
   input  logic                    rst_i,
   input  logic                    cfg_en_i,
   input  logic [LEN_WIDTH-1:0]    cfg_frame_len_i,
   input  logic [FILTID_WIDTH-1:0] cfg_stream_id_i,
   input  logic [1:0]              cfg_datasize_i,
   udma_stream_framer_if.slave     strm,
   output logic                    frame_evt_o,
   output logic [LEN_WIDTH-1:0]    frame_cnt_o,
   output logic                    busy_o
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int ENTRY_W = DATA_WIDTH + 2 + FILTID_WIDTH + 2;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]              state_q, state_d;
   logic [LEN_WIDTH-1:0]    beat_cnt_q, beat_cnt_d;
   logic [LEN_WIDTH-1:0]    len_q, len_d;
   logic [FILTID_WIDTH-1:0] id_q, id_d;
   logic [1:0]              ds_q, ds_d;
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]          count_q, count_d;
   logic                    frame_evt_q, frame_evt_d;
   logic [LEN_WIDTH-1:0]    frame_cnt_q, frame_cnt_d;
   logic [ENTRY_W-1:0]      mem_q [FIFO_DEPTH];

   logic                    frame_start;
   logic [LEN_WIDTH-1:0]    cfg_len_eff;
   logic [LEN_WIDTH-1:0]    cur_len;
   logic [LEN_WIDTH-1:0]    beat_idx;
   logic                    beat_eot;
   logic                    in_ready;
   logic                    push;
   logic                    pop;
   logic                    fifo_nempty;
   logic [ENTRY_W-1:0]      entry;
   logic [ENTRY_W-1:0]      head;

   assign frame_start = (beat_cnt_q == '0);
   assign cfg_len_eff = (cfg_frame_len_i == '0) ? LEN_WIDTH'(1) : cfg_frame_len_i;
   assign cur_len     = frame_start ? cfg_len_eff : len_q;
   assign beat_idx    = beat_cnt_q + LEN_WIDTH'(1);
   assign beat_eot    = (beat_idx == cur_len);
   assign fifo_nempty = (count_q != '0);

   // At a frame boundary with enable low no new frame may start, otherwise a
   // frame would open on the same cycle the FSM leaves RUN.
   assign in_ready = (state_q == ST_RUN) && (count_q < FULL_CNT) &&
                     !(frame_start && !cfg_en_i);
   assign push     = strm.in_valid_i && in_ready;
   assign pop      = fifo_nempty && strm.str_ready_i;

   assign entry = {strm.in_data_i,
                   frame_start ? cfg_datasize_i  : ds_q,
                   frame_start ? cfg_stream_id_i : id_q,
                   frame_start, beat_eot};
   assign head  = fifo_nempty ? mem_q[rd_ptr_q] : '0;

   always_comb begin
      state_d     = state_q;
      beat_cnt_d  = beat_cnt_q;
      len_d       = len_q;
      id_d        = id_q;
      ds_d        = ds_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      frame_evt_d = 1'b0;
      frame_cnt_d = frame_cnt_q;

      case (state_q)
         ST_IDLE:  if (cfg_en_i) state_d = ST_RUN;
         ST_RUN:   if (!cfg_en_i && frame_start) state_d = ST_DRAIN;
         ST_DRAIN: begin
            if (cfg_en_i)          state_d = ST_RUN;
            else if (!fifo_nempty) state_d = ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase

      if (push) begin
         if (frame_start) begin
            len_d = cfg_len_eff;
            id_d  = cfg_stream_id_i;
            ds_d  = cfg_datasize_i;
         end
         beat_cnt_d = beat_eot ? '0 : beat_idx;
         wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (head[0]) begin
            frame_evt_d = 1'b1;
            frame_cnt_d = frame_cnt_q + LEN_WIDTH'(1);
         end
      end

      case ({push, pop})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge sys_clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         beat_cnt_q  <= '0;
         len_q       <= '0;
         id_q        <= '0;
         ds_q        <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         frame_evt_q <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         beat_cnt_q  <= beat_cnt_d;
         len_q       <= len_d;
         id_q        <= id_d;
         ds_q        <= ds_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         frame_evt_q <= frame_evt_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // Storage needs no reset: the empty buffer masks its contents.
   always_ff @(posedge sys_clk_i) begin
      if (push) mem_q[wr_ptr_q] <= entry;
   end

   assign strm.in_ready_o      = in_ready;
   assign strm.str_valid_o     = fifo_nempty;
   assign strm.str_data_o      = head[ENTRY_W-1 -: DATA_WIDTH];
   assign strm.str_datasize_o  = head[FILTID_WIDTH+3 -: 2];
   assign strm.str_stream_id_o = head[FILTID_WIDTH+1 -: FILTID_WIDTH];
   assign strm.str_sot_o       = head[1];
   assign strm.str_eot_o       = head[0];

   assign frame_evt_o = frame_evt_q;
   assign frame_cnt_o = frame_cnt_q;
   assign busy_o      = (state_q != ST_IDLE) || fifo_nempty;

endmodule

// File: tb/tb_udma_stream_framer.sv
module tb_udma_stream_framer;
   localparam int DW    = 32;
   localparam int IW    = udma_pkg::STREAM_ID_WIDTH;
   localparam int LW    = 4;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_en = 1'b0;
   logic [LW-1:0] cfg_len = '0;
   logic [IW-1:0] cfg_id = '0;
   logic [1:0]    cfg_ds = '0;
   logic          frame_evt;
   logic [LW-1:0] frame_cnt;
   logic          busy;

   udma_stream_framer_if #(.DATA_WIDTH(DW), .FILTID_WIDTH(IW)) bus ();

   udma_stream_framer #(
      .DATA_WIDTH(DW), .FILTID_WIDTH(IW), .LEN_WIDTH(LW), .FIFO_DEPTH(DEPTH)
   ) dut (
      .sys_clk_i       (clk),
      .rst_i           (rst),
      .cfg_en_i        (cfg_en),
      .cfg_frame_len_i (cfg_len),
      .cfg_stream_id_i (cfg_id),
      .cfg_datasize_i  (cfg_ds),
      .strm            (bus),
      .frame_evt_o     (frame_evt),
      .frame_cnt_o     (frame_cnt),
      .busy_o          (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      logic [1:0]    ds;
      logic [IW-1:0] id;
      logic          sot;
      logic          eot;
   } beat_t;

   beat_t    mq[$];
   beat_t    out_log[$];
   int       m_pos = 0;
   int       m_len = 1;
   logic [IW-1:0] m_id;
   logic [1:0]    m_ds;
   logic          exp_evt = 1'b0;
   logic [LW-1:0] exp_cnt = '0;
   int       tests = 0;
   int       fails = 0;
   int       evt_seen = 0;
   bit       chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of expected beats, frame position tracked as
   // plain integers, frame completions counted on delivered eot beats.
   always @(posedge clk) begin
      beat_t b;
      beat_t a;
      if (rst) begin
         mq.delete();
         m_pos   = 0;
         exp_evt = 1'b0;
         exp_cnt = '0;
      end else begin
         exp_evt = 1'b0;
         if (bus.str_valid_o && bus.str_ready_i) begin
            a.data = bus.str_data_o; a.ds = bus.str_datasize_o;
            a.id = bus.str_stream_id_o; a.sot = bus.str_sot_o; a.eot = bus.str_eot_o;
            out_log.push_back(a);
            if (mq.size() > 0) begin
               b = mq.pop_front();
               if (b.eot) begin
                  exp_evt = 1'b1;
                  exp_cnt = exp_cnt + 1'b1;
               end
            end
         end
         if (bus.in_valid_i && bus.in_ready_o) begin
            if (m_pos == 0) begin
               m_len = (cfg_len == 0) ? 1 : int'(cfg_len);
               m_id  = cfg_id;
               m_ds  = cfg_ds;
            end
            b.data = bus.in_data_i;
            b.ds   = m_ds;
            b.id   = m_id;
            b.sot  = (m_pos == 0);
            m_pos++;
            b.eot  = (m_pos == m_len);
            if (b.eot) m_pos = 0;
            mq.push_back(b);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("str_valid", 32'(bus.str_valid_o), 32'(mq.size() != 0));
         if (mq.size() != 0) begin
            chk("str_data", bus.str_data_o, mq[0].data);
            chk("str_datasize", 32'(bus.str_datasize_o), 32'(mq[0].ds));
            chk("str_stream_id", 32'(bus.str_stream_id_o), 32'(mq[0].id));
            chk("str_sot", 32'(bus.str_sot_o), 32'(mq[0].sot));
            chk("str_eot", 32'(bus.str_eot_o), 32'(mq[0].eot));
            chk("busy_nonempty", 32'(busy), 32'd1);
         end
         if (mq.size() >= DEPTH) chk("in_ready_full", 32'(bus.in_ready_o), 32'd0);
         chk("frame_evt", 32'(frame_evt), 32'(exp_evt));
         chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
         if (frame_evt) evt_seen++;
      end
   end

   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1;
      bus.in_valid_i = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      out_log.delete();
      evt_seen = 0;
   endtask

   task automatic send(input logic [DW-1:0] d);
      int n;
      n = 0;
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = d;
      #1;
      while (!bus.in_ready_o && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 200) chk("send_timeout", 32'd1, 32'd0);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid_i = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.in_valid_i  = 1'b0;
      bus.in_data_i   = '0;
      bus.str_ready_i = 1'b0;

      // reset state
      reset_dut();
      #1;
      chk("rst_in_ready", 32'(bus.in_ready_o), 32'd0);
      chk("rst_str_valid", 32'(bus.str_valid_o), 32'd0);
      chk("rst_str_data", bus.str_data_o, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);

      // nominal frame
      cfg_len = 4'd3; cfg_id = 8'd1; cfg_ds = 2'd2; cfg_en = 1'b1;
      bus.str_ready_i = 1'b1;
      send(32'hA); send(32'hB); send(32'hC);
      idle(4);
      chk("nom_count", out_log.size(), 32'd3);
      if (out_log.size() == 3) begin
         chk("nom_b0", {out_log[0].data[7:0], 3'b0, out_log[0].sot, out_log[0].eot},
             {8'hA, 3'b0, 1'b1, 1'b0});
         chk("nom_b1", {out_log[1].data[7:0], 3'b0, out_log[1].sot, out_log[1].eot},
             {8'hB, 3'b0, 1'b0, 1'b0});
         chk("nom_b2", {out_log[2].data[7:0], 3'b0, out_log[2].sot, out_log[2].eot},
             {8'hC, 3'b0, 1'b0, 1'b1});
         chk("nom_id_ds", {out_log[2].id, out_log[2].ds}, {8'd1, 2'd2});
      end
      chk("nom_evts", evt_seen, 32'd1);
      chk("nom_frame_cnt", 32'(frame_cnt), 32'd1);

      // length 0 behaves as length 1
      reset_dut();
      cfg_len = 4'd0;
      send(32'h11); send(32'h22);
      idle(4);
      chk("len0_count", out_log.size(), 32'd2);
      if (out_log.size() == 2) begin
         chk("len0_b0", {out_log[0].data[7:0], out_log[0].sot, out_log[0].eot}, {8'h11, 2'b11});
         chk("len0_b1", {out_log[1].data[7:0], out_log[1].sot, out_log[1].eot}, {8'h22, 2'b11});
      end
      chk("len0_frame_cnt", 32'(frame_cnt), 32'd2);

      // backpressure
      reset_dut();
      cfg_len = 4'd8; cfg_id = 8'h5A; cfg_ds = 2'd1;
      bus.str_ready_i = 1'b0;
      for (int i = 1; i <= 4; i++) send(32'h100 + i);
      #1;
      chk("bp_in_ready", 32'(bus.in_ready_o), 32'd0);
      chk("bp_head_data", bus.str_data_o, 32'h101);
      idle(3);
      chk("bp_hold_data", bus.str_data_o, 32'h101);
      bus.str_ready_i = 1'b1;
      for (int i = 5; i <= 8; i++) send(32'h100 + i);
      idle(6);
      chk("bp_count", out_log.size(), 32'd8);
      for (int i = 0; i < 8 && i < out_log.size(); i++)
         chk("bp_order", out_log[i].data, 32'h101 + i);
      chk("bp_evts", evt_seen, 32'd1);

      // mid-frame enable and length change
      reset_dut();
      cfg_len = 4'd4; cfg_id = 8'h33; cfg_ds = 2'd3; cfg_en = 1'b1;
      send(32'h41); send(32'h42);
      cfg_en = 1'b0; cfg_len = 4'd2;
      send(32'h43); send(32'h44);
      idle(6);
      chk("mid_count", out_log.size(), 32'd4);
      if (out_log.size() == 4) begin
         chk("mid_b1_eot", 32'(out_log[1].eot), 32'd0);
         chk("mid_b3", {out_log[3].data[7:0], out_log[3].eot}, {8'h44, 1'b1});
      end
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_in_ready", 32'(bus.in_ready_o), 32'd0);

      // reset mid-frame
      reset_dut();
      cfg_len = 4'd4; cfg_en = 1'b1;
      bus.str_ready_i = 1'b0;
      send(32'h51); send(32'h52);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rmid_str_valid", 32'(bus.str_valid_o), 32'd0);
      chk("rmid_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("rmid_str_data", bus.str_data_o, 32'd0);
      chk("rmid_busy", 32'(busy), 32'd0);
      chk("rmid_evts", evt_seen, 32'd0);
      bus.str_ready_i = 1'b1;
      for (int i = 1; i <= 4; i++) send(32'h60 + i);
      idle(6);
      chk("rmid_count", out_log.size(), 32'd4);
      if (out_log.size() == 4) begin
         chk("rmid_first", {out_log[0].data[7:0], out_log[0].sot}, {8'h61, 1'b1});
         chk("rmid_last_eot", 32'(out_log[3].eot), 32'd1);
      end
      chk("rmid_frame_cnt_after", 32'(frame_cnt), 32'd1);

      // frame counter wrap at LEN_WIDTH=4
      reset_dut();
      cfg_len = 4'd1; cfg_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         send(32'h200 + i);
         idle(3);
         if (i == 14) chk("wrap_15", 32'(frame_cnt), 32'd15);
         if (i == 15) chk("wrap_0", 32'(frame_cnt), 32'd0);
      end
      chk("wrap_evts", evt_seen, 32'd16);

      cfg_en = 1'b0;
      idle(4);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/udma_stream_framer.md
UDMA_STREAM_FRAMER -- requirements
Module: udma_stream_framer

Interface
REQ-001 The block SHALL have one clock, sys_clk_i; reset is synchronous and active-high, port rst_i.
REQ-002 The block SHALL provide these parameters:
- DATA_WIDTH, default 32: payload width.
- FILTID_WIDTH, default udma_pkg::STREAM_ID_WIDTH: stream id width.
- LEN_WIDTH, default 16: frame-length and frame-counter width.
- FIFO_DEPTH, default 4: output buffer entries, power of two, at least 2.
REQ-003 The block SHALL provide these ports, clock and reset first:
- sys_clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- cfg_en_i  in  1  framing enable.
- cfg_frame_len_i  in  LEN_WIDTH  beats per frame; 0 is treated as 1.
- cfg_stream_id_i  in  FILTID_WIDTH  id stamped on the frame.
- cfg_datasize_i  in  2  datasize stamped on the frame.
- in_data_i  in  DATA_WIDTH  peripheral sample.
- in_valid_i  in  1  sample valid.
- in_ready_o  out  1  sample accepted.
- str_data_o  out  DATA_WIDTH  stream payload to the filter.
- str_datasize_o  out  2  stream datasize.
- str_stream_id_o  out  FILTID_WIDTH  stream id.
- str_valid_o  out  1  stream beat valid.
- str_sot_o  out  1  first beat of frame.
- str_eot_o  out  1  last beat of frame.
- str_ready_i  in  1  filter ready.
- frame_evt_o  out  1  one-cycle pulse per completed frame.
- frame_cnt_o  out  LEN_WIDTH  completed-frame count.
- busy_o  out  1  frame in progress or buffer non-empty.

Function
REQ-004 The FSM SHALL have three states: IDLE, RUN and DRAIN.
- IDLE to RUN when cfg_en_i=1.
- RUN to DRAIN when cfg_en_i=0 and the beat counter is 0 (frame boundary).
- DRAIN to IDLE when the FIFO is empty.
- DRAIN to RUN when cfg_en_i=1.
REQ-005 in_ready_o SHALL be 1 only in RUN with FIFO count below FIFO_DEPTH; it SHALL NOT depend combinationally on str_ready_i.
REQ-006 An input handshake SHALL be in_valid_i and in_ready_o both 1 on a rising edge.
REQ-007 On the first handshake of a frame (beat counter 0), the block SHALL latch cfg_frame_len_i, cfg_stream_id_i and cfg_datasize_i; config changes mid-frame SHALL NOT affect that frame.
REQ-008 The beat counter SHALL increment on each input handshake and return to 0 on the handshake of beat L, where L is the latched length (0 treated as 1).
REQ-009 Each FIFO entry SHALL store {data, datasize, id, sot, eot}.
- sot=1 on beat 1.
- eot=1 on beat L.
- When L=1, the single beat SHALL carry both sot and eot.
REQ-010 If cfg_en_i falls mid-frame, the block SHALL stay in RUN and keep accepting input until beat L, then enter DRAIN.
REQ-011 The FIFO SHALL be registered with no fall-through: a beat accepted at edge t SHALL appear on str_*_o at t+1 at the earliest.
REQ-012 str_valid_o SHALL equal FIFO non-empty; the FIFO SHALL pop on str_valid_o and str_ready_i both 1.
REQ-013 While str_valid_o=1 and str_ready_i=0, str_*_o SHALL hold stable.
REQ-014 Push and pop in the same cycle SHALL leave the count unchanged; a push when full is impossible per REQ-005.
REQ-015 frame_evt_o SHALL pulse for exactly one cycle, on the cycle after an output handshake with str_eot_o=1.
REQ-016 frame_cnt_o SHALL increment at that same edge and wrap from 2^LEN_WIDTH-1 to 0.
REQ-017 busy_o SHALL be 1 when state is not IDLE or the FIFO count is non-zero.

Reset
REQ-018 While rst_i=1, on each rising edge, the block SHALL:
- set state to IDLE;
- clear the FIFO pointers and count, the beat counter and frame_cnt_o;
- drive in_ready_o, str_valid_o, str_sot_o, str_eot_o, frame_evt_o and busy_o to 0;
- drive str_data_o, str_datasize_o and str_stream_id_o to 0.
REQ-019 A reset mid-frame SHALL discard all partial-frame and buffered beats; no eot beat and no frame_evt_o SHALL be emitted for the discarded frame.

Verification
REQ-020 Nominal frame: len=3, id=1, datasize=2, str_ready_i=1, inputs 0xA,0xB,0xC back-to-back -> outputs 0xA(sot),0xB,0xC(eot), id=1, datasize=2; frame_evt_o pulses once; frame_cnt_o=1.
REQ-021 Length 0/1: len=0, inputs 0x11,0x22 -> two beats, each with sot=eot=1; frame_cnt_o=2.
REQ-022 Backpressure: len=8, str_ready_i=0 -> in_ready_o falls after FIFO_DEPTH=4 accepts; str_data_o holds 1st beat; after str_ready_i=1, all 8 beats are delivered in order and none are lost.
REQ-023 Mid-frame changes: len=4, after beat 2 set cfg_en_i=0 and cfg_frame_len_i=2 -> beats 3,4 still accepted, eot on beat 4; then DRAIN to IDLE; busy_o=0 once the FIFO is empty.
REQ-024 Reset mid-frame: len=4, 2 beats accepted and stalled, rst_i=1 for one cycle -> str_valid_o=0, frame_cnt_o=0, no frame_evt_o; next frame starts with sot.
REQ-025 Counter wrap: LEN_WIDTH=4, 16 frames of len=1 -> frame_cnt_o reads 15 then 0.
